// File: rtl/synth_pkg.sv
// Shared types for the synthesizer wave-type controller.
//   wave_t       : waveform selection code driven to the waveform mux
//   ctrl_state_t : wave_type_ctrl sequencing states
//   next_wave    : modulo-4 step through the wave sequence
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_OFF    = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_SAW    = 2'b10,
    WAVE_TRI    = 2'b11
  } wave_t;

  typedef enum logic {
    CTRL_IDLE    = 1'b0,
    CTRL_PENDING = 1'b1
  } ctrl_state_t;

  // OFF -> SQUARE -> SAW -> TRI -> OFF
  function automatic wave_t next_wave(input wave_t w);
    logic [1:0] v;
    v = w;
    return wave_t'(v + 2'd1);
  endfunction

endpackage

// File: rtl/wave_type_ctrl_debounce.sv
// button_debounce: 2-flop synchronizer, stability counter and rising-edge
// detector for the raw front-panel button.
//   clk, nrst  : clock, asynchronous active-low reset
//   button_in  : raw asynchronous button, active-high
//   level      : debounced button level
//   press      : one-cycle pulse when the debounced level rises
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic button_in,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt_q;

  // Count consecutive samples that disagree with the debounced level; the
  // DEBOUNCE_CYCLES-th disagreeing sample flips the level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt_q   <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= button_in;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 != level) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_q2;
          cnt_q <= '0;
          press <= sync_q2;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/wave_type_ctrl.sv
// wave_type_ctrl: advances a pending wave type on each debounced button press
// and commits it to the waveform mux at the oscillator phase wrap, or after
// a timeout when the oscillator is idle.
//   clk, nrst   : clock, asynchronous active-low reset
//   button      : raw wave-type button, active-high
//   phase_wrap  : one-cycle strobe at oscillator phase wrap
//   type_switch : committed wave type (wave_t)
//   pending     : a selected type awaits commit
//   switched    : one-cycle pulse after type_switch is (re)committed
module wave_type_ctrl
  import synth_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic  clk,
  input  logic  nrst,
  input  logic  button,
  input  logic  phase_wrap,
  output wave_t type_switch,
  output logic  pending,
  output logic  switched
);

  localparam int unsigned TIMER_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TIMER_MAX = TIMEOUT_CYCLES - 1;

  logic press;
  logic level_unused;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .nrst     (nrst),
    .button_in(button),
    .level    (level_unused),
    .press    (press)
  );

  ctrl_state_t        state_q, state_d;
  wave_t              target_q, target_d;
  wave_t              type_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               switched_d;
  wave_t              target_eff;
  logic               commit;

  // State and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= CTRL_IDLE;
      target_q    <= WAVE_OFF;
      timer_q     <= '0;
      type_switch <= WAVE_OFF;
      pending     <= 1'b0;
      switched    <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      timer_q     <= timer_d;
      type_switch <= type_d;
      pending     <= (state_d == CTRL_PENDING);
      switched    <= switched_d;
    end
  end

  // A press landing on the commit cycle is folded into the committed value.
  assign target_eff = press ? next_wave(target_q) : target_q;
  assign commit     = (state_q == CTRL_PENDING) &&
                      (phase_wrap || (timer_q == TIMER_W'(TIMER_MAX)));

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    type_d     = type_switch;
    timer_d    = timer_q;
    switched_d = 1'b0;
    case (state_q)
      CTRL_IDLE: begin
        if (press) begin
          target_d = next_wave(type_switch);
          timer_d  = '0;
          state_d  = CTRL_PENDING;
        end
      end
      CTRL_PENDING: begin
        target_d = target_eff;
        if (commit) begin
          type_d     = target_eff;
          switched_d = 1'b1;
          timer_d    = '0;
          state_d    = CTRL_IDLE;
        end else if (timer_q != TIMER_W'(TIMER_MAX)) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = CTRL_IDLE;
      end
    endcase
  end

endmodule
